// File: rtl/note_stream_pkg.sv
// Shared constants and note-to-phase-increment decode for the note oscillator.
package note_stream_pkg;

  localparam int unsigned PHASE_W   = 32;
  localparam int unsigned OUT_W     = 9;
  localparam int unsigned NUM_NOTES = 60;

  // C2..B2 increments: round(f * 2^32 / 50e6)
  localparam logic [15:0] BASE [12] = '{
    16'd5618, 16'd5952, 16'd6306, 16'd6681, 16'd7079, 16'd7500,
    16'd7946, 16'd8418, 16'd8919, 16'd9449, 16'd10011, 16'd10606
  };

  typedef enum logic [1:0] {
    OCT_NONE = 2'd0,
    OCT_UP   = 2'd1,
    OCT_DOWN = 2'd2,
    OCT_RSVD = 2'd3
  } octave_change_e;

  function automatic logic note_valid(input logic [5:0] note);
    return (note != 6'd0) && (32'(note) <= NUM_NOTES);
  endfunction

  function automatic logic [PHASE_W-1:0] note_to_inc(input logic [5:0] note,
                                                     input octave_change_e octaveChange);
    logic [PHASE_W-1:0] inc;
    logic [5:0]         idx;
    logic [3:0]         semi;
    logic [2:0]         oct;
    inc = '0;
    if (note_valid(note)) begin
      idx  = note - 6'd1;
      semi = 4'(idx % 6'd12);
      oct  = 3'(idx / 6'd12);
      inc  = PHASE_W'(BASE[semi]) << oct;
      case (octaveChange)
        OCT_UP:   inc = inc << 1;
        OCT_DOWN: inc = inc >> 1;
        default:  ;
      endcase
    end
    return inc;
  endfunction

endpackage

// File: rtl/note_channel.sv
// One oscillator channel: phase accumulator producing a sawtooth sample.
module note_channel
  import note_stream_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [5:0]       note,
  input  logic [1:0]       octaveChange,
  output logic [OUT_W-1:0] sample
);

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] inc;
  logic               valid;

  always_comb begin
    inc   = note_to_inc(note, octave_change_e'(octaveChange));
    valid = note_valid(note);
  end

  // Rests clear the phase only while enabled; en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      if (valid) acc <= acc + inc;
      else       acc <= '0;
    end
  end

  assign sample = acc[PHASE_W-1 -: OUT_W];

endmodule

// File: rtl/note_stream_gen.sv
// Dual-channel sawtooth note oscillator; octave offset is shared by both channels.
module note_stream_gen
  import note_stream_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       octaveChange,
  input  logic [5:0]       Notes1_in,
  input  logic [5:0]       Notes2_in,
  output logic [OUT_W-1:0] NoteStream1_out,
  output logic [OUT_W-1:0] NoteStream2_out
);

  note_channel u_ch1 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .note         (Notes1_in),
    .octaveChange (octaveChange),
    .sample       (NoteStream1_out)
  );

  note_channel u_ch2 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .note         (Notes2_in),
    .octaveChange (octaveChange),
    .sample       (NoteStream2_out)
  );

endmodule

// File: tb/tb_note_stream_gen.sv
// Scoreboard bench for note_stream_gen: a reference phase model predicts samples each cycle.
module tb_note_stream_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] octaveChange;
  logic [5:0] Notes1_in;
  logic [5:0] Notes2_in;
  logic [8:0] NoteStream1_out;
  logic [8:0] NoteStream2_out;

  note_stream_gen dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .octaveChange    (octaveChange),
    .Notes1_in       (Notes1_in),
    .Notes2_in       (Notes2_in),
    .NoteStream1_out (NoteStream1_out),
    .NoteStream2_out (NoteStream2_out)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [8:0] s1;
    logic [8:0] s2;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [31:0] m_acc1, m_acc2;
  int unsigned base_tab [12] = '{5618, 5952, 6306, 6681, 7079, 7500,
                                 7946, 8418, 8919, 9449, 10011, 10606};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_inc(input int n, input int oc);
    longint v;
    if (n < 1 || n > 60) return 32'd0;
    v = longint'(base_tab[(n - 1) % 12]) * (longint'(1) << ((n - 1) / 12));
    if (oc == 1)      v = v * 2;
    else if (oc == 2) v = v / 2;
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a, input int n);
    if (reset)     return 32'd0;
    if (!en)       return a;
    if (n < 1 || n > 60) return 32'd0;
    return a + model_inc(n, int'(octaveChange));
  endfunction

  // Predict, push, clock, then pop and compare just after the edge.
  task automatic tick();
    exp_t e;
    m_acc1 = model_next(m_acc1, int'(Notes1_in));
    m_acc2 = model_next(m_acc2, int'(Notes2_in));
    e.s1 = m_acc1[31:23];
    e.s2 = m_acc2[31:23];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("out1", 32'(NoteStream1_out), 32'(e.s1));
    check_eq("out2", 32'(NoteStream2_out), 32'(e.s2));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [8:0] prev;
  logic       wrapped;

  initial begin
    m_acc1 = 32'hDEAD_BEEF;
    m_acc2 = 32'h1234_5678;
    reset = 1'b1; en = 1'b1; octaveChange = 2'd1;
    Notes1_in = 6'd33; Notes2_in = 6'd7;
    @(negedge clk);

    // Reset held for 3 clocks with arbitrary inputs
    run(3);
    check_eq("rst_acc1", dut.u_ch1.acc, 32'd0);
    check_eq("rst_acc2", dut.u_ch2.acc, 32'd0);

    // Steady tone
    reset = 1'b0; octaveChange = 2'd0; Notes1_in = 6'd10; Notes2_in = 6'd11;
    run(20000);
    check_eq("tone_acc1", dut.u_ch1.acc, 32'd188980000);
    check_eq("tone_acc2", dut.u_ch2.acc, 32'd200220000);
    check_eq("tone_out1", 32'(NoteStream1_out), 32'd22);
    check_eq("tone_out2", 32'(NoteStream2_out), 32'd23);

    // Rest / invalid codes on channel 1; channel 2 keeps running
    Notes1_in = 6'd0;  run(5);
    check_eq("rest0_out1", 32'(NoteStream1_out), 32'd0);
    Notes1_in = 6'd10; run(300);
    Notes1_in = 6'd62; run(5);
    check_eq("rest62_acc1", dut.u_ch1.acc, 32'd0);
    check_eq("rest_acc2", dut.u_ch2.acc, 32'(200220000 + 310 * 10011));

    // Octave shifts on note 1
    Notes1_in = 6'd1;
    octaveChange = 2'd1; do_reset(); run(10);
    check_eq("oct_up", dut.u_ch1.acc, 32'd112360);
    octaveChange = 2'd2; do_reset(); run(10);
    check_eq("oct_down", dut.u_ch1.acc, 32'd28090);
    octaveChange = 2'd3; do_reset(); run(10);
    check_eq("oct_rsvd", dut.u_ch1.acc, 32'd56180);

    // Enable hold, including a rest code presented while frozen
    octaveChange = 2'd0; Notes1_in = 6'd5; Notes2_in = 6'd20;
    run(3000);
    en = 1'b0; run(50);
    Notes1_in = 6'd0; run(50);
    check_eq("hold_acc1", dut.u_ch1.acc, m_acc1);
    check_eq("hold_acc2", dut.u_ch2.acc, m_acc2);
    Notes1_in = 6'd5; en = 1'b1; run(50);

    // Wrap-around on the top note, then reset mid-run
    Notes1_in = 6'd60; octaveChange = 2'd1; do_reset();
    check_eq("inc60", model_inc(60, 1), 32'd339392);
    wrapped = 1'b0;
    for (int unsigned i = 0; i < 20000 && !wrapped; i++) begin
      prev = NoteStream1_out;
      tick();
      if (NoteStream1_out < prev) wrapped = 1'b1;
    end
    check_eq("wrap_seen", 32'(wrapped), 32'd1);
    run(20);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("midrst_out1", 32'(NoteStream1_out), 32'd0);
    check_eq("midrst_out2", 32'(NoteStream2_out), 32'd0);
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/note_stream_gen.md
Name: note_stream_gen

Overview:
- Dual-channel note oscillator for the music synthesizer.
- Each channel converts a 6-bit note number into a phase increment using a semitone LUT, an octave shift and a global octave offset.
- Each channel accumulates phase at the system clock and emits a 9-bit unsigned sawtooth sample stream.
- Sits between the note/key decoder (upstream) and the mixer/audio DAC path (downstream).

Parameters:
- PHASE_W, 32, phase accumulator width in bits.
- OUT_W, 9, sample width; output is acc[PHASE_W-1 -: OUT_W].
- NUM_NOTES, 60, highest valid note code; codes above this are rests.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high; clears all state.
- en  in  1  accumulate enable; 0 freezes both accumulators.
- octaveChange  in  2  global octave offset: 0 none, 1 up one octave, 2 down one octave, 3 treated as 0.
- Notes1_in  in  6  channel 1 note code; 0 = rest, 1..60 = C2..B6.
- Notes2_in  in  6  channel 2 note code; same encoding as Notes1_in.
- NoteStream1_out  out  9  channel 1 sawtooth sample, unsigned.
- NoteStream2_out  out  9  channel 2 sawtooth sample, unsigned.

Behaviour:
- Reset: at a clk edge with reset=1, both accumulators become 0, so both outputs read 0. Reset overrides en and all note inputs. Reset asserted mid-note clears the phase on that edge.
- Note decode, combinational, per channel, for n in 1..60:
  - o = (n-1)/12, s = (n-1)%12.
  - base = BASE[s], with BASE = {5618, 5952, 6306, 6681, 7079, 7500, 7946, 8418, 8919, 9449, 10011, 10606} (C2..B2; round(f·2^32/50e6)).
  - inc = base << o.
  - octaveChange=1: inc <<= 1. octaveChange=2: inc >>= 1 (truncating).
  - Maximum inc is 10606<<5, which fits in 32 bits.
- Update on each clk edge, with reset=0 and en=1:
  - Valid note: acc <= acc + inc, mod 2^PHASE_W. Wrap-around is natural overflow.
  - Rest code (0 or 61..63): acc <= 0.
- With reset=0 and en=0: acc holds. A rest is not applied while en=0.
- Output: NoteStreamX_out = acc[31:23], taken directly from the register with no extra pipeline. The output reflects the accumulator after each edge, so latency from a note input to the increment taking effect is 1 cycle.
- Note changes are phase-continuous: the accumulator is not cleared when the code changes between two valid notes.
- Inputs are sampled every edge with no handshake or latching. Channels are fully independent, except that octaveChange applies to both.
- No state machine; the only state is the two accumulators.

Decomposition:
- Shared package note_stream_pkg holds:
  - PHASE_W, OUT_W, NUM_NOTES.
  - The 12-entry BASE increment constant array.
  - An octave_change_e enum (OCT_NONE=0, OCT_UP=1, OCT_DOWN=2, OCT_RSVD=3).
  - A function note_to_inc(note, octaveChange) returning the 32-bit increment.
- One sub-module, note_channel (clk, reset, en, note, octaveChange → sample), instantiated twice by note_stream_gen.

Test Plan:
- Reset: hold reset=1 for 3 clocks with any inputs → both outputs 0; accumulators 0.
- Steady tone: reset released, en=1, octaveChange=0, Notes1_in=10, Notes2_in=11; after exactly 20000 clocks → acc1=188,980,000 and NoteStream1_out=22; acc2=200,220,000 and NoteStream2_out=23.
- Octave shift: Notes1_in=1, octaveChange=1 → inc 11236, so acc1=11236·k after k clocks. With octaveChange=2 → inc 2809. With octaveChange=3 → inc 5618.
- Rest/invalid: Notes1_in set to 0, then 62, mid-tone → NoteStream1_out is 0 on the next cycle and stays 0. Channel 2 is unaffected.
- Enable hold: en=0 for 100 clocks mid-tone → both outputs and accumulators unchanged. Re-enable → accumulation resumes from the held value.
- Wrap and reset mid-run: Notes1_in=60, octaveChange=1 (inc 339392); run until the output passes 511 and wraps to a small value. Assert reset one cycle → outputs 0 on the following edge.
